// File: rtl/signed_spatial_acc.sv
// Signed spatial accumulator: shifts each incoming product by its temporal shift and sums it into a group result.
// Define SIGNED_SPATIAL_ACC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module signed_spatial_acc #(
  parameter int unsigned PRECISION      = 8,
  parameter int unsigned L_PRECISION    = 2,
  parameter int unsigned MULT_OUT_WIDTH = 2*PRECISION,
  parameter int unsigned ACC_WIDTH      = 32,
  parameter int unsigned SHIFT_WIDTH    = 3,
  parameter int unsigned SHIFT_MAX      = 2*PRECISION/L_PRECISION - 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [MULT_OUT_WIDTH-1:0] in_product,
  input  logic [SHIFT_WIDTH-1:0]    in_shift,
  input  logic                      in_first,
  input  logic                      in_last,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [ACC_WIDTH-1:0]      out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      overflow
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                 state;
  logic                   s1_valid;
  logic                   s1_first;
  logic                   s1_last;
  logic [ACC_WIDTH-1:0]   s1_value;
  logic [ACC_WIDTH-1:0]   acc;
  logic                   grp_ovf;

  logic                   stall;
  logic                   advance;
  logic [SHIFT_WIDTH-1:0] shift_eff;
  int unsigned            shamt;
  logic [ACC_WIDTH-1:0]   ext;
  logic [ACC_WIDTH-1:0]   shifted;
  logic [ACC_WIDTH-1:0]   base;
  logic [ACC_WIDTH-1:0]   sum;
  logic [ACC_WIDTH-1:0]   acc_next;
  logic                   add_ovf;
  logic                   ovf_next;

  // A completed group waiting in stage 1 can only move on once the output register is free.
  assign stall    = s1_valid && s1_last && out_valid && !out_ready;
  assign in_ready = !stall;
  assign advance  = s1_valid && !stall;

  always_comb begin
    shift_eff = in_shift;
    if (32'(in_shift) > SHIFT_MAX) shift_eff = SHIFT_WIDTH'(SHIFT_MAX);
    shamt   = 32'(shift_eff) * L_PRECISION;
    ext     = {{(ACC_WIDTH-MULT_OUT_WIDTH){in_product[MULT_OUT_WIDTH-1]}}, in_product};
    shifted = ext << shamt;
  end

  always_comb begin
    base     = s1_first ? '0 : acc;
    sum      = base + s1_value;
    add_ovf  = (base[ACC_WIDTH-1] == s1_value[ACC_WIDTH-1]) &&
               (sum[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
    acc_next = sum;
`ifdef SIGNED_SPATIAL_ACC_SAT_EN
    if (add_ovf) begin
      acc_next = base[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                   : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
`endif
    ovf_next = (s1_first ? 1'b0 : grp_ovf) | add_ovf;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_value  <= '0;
      acc       <= '0;
      grp_ovf   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (!stall) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_value <= shifted;
          s1_first <= in_first;
          s1_last  <= in_last;
        end
      end

      if (out_valid && out_ready) out_valid <= 1'b0;

      if (advance) begin
        if (s1_last) begin
          acc       <= '0;
          grp_ovf   <= 1'b0;
          out_data  <= acc_next;
          overflow  <= ovf_next;
          out_valid <= 1'b1;
        end else begin
          acc     <= acc_next;
          grp_ovf <= ovf_next;
        end

        // A first product in ACCUM restarts the group; the datapath already discarded the partial sum.
        unique case (state)
          IDLE:    state <= s1_last ? IDLE : ACCUM;
          ACCUM:   state <= s1_last ? IDLE : ACCUM;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_signed_spatial_acc.sv
// Scoreboard bench for signed_spatial_acc: directed groups push expected sums, a monitor checks each output transfer.
module tb_signed_spatial_acc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_product = '0;
  logic [2:0]  in_shift = '0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_data[$];
  logic        exp_ovf[$];
  string       exp_name[$];

  logic [31:0] cur_data;
  logic        cur_ovf;
  string       cur_name;

  signed_spatial_acc #(
    .PRECISION(8),
    .L_PRECISION(2),
    .ACC_WIDTH(32),
    .SHIFT_WIDTH(3)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .in_product(in_product),
    .in_shift(in_shift),
    .in_first(in_first),
    .in_last(in_last),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_data.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%h required=none", out_data);
      end else begin
        cur_data = exp_data.pop_front();
        cur_ovf  = exp_ovf.pop_front();
        cur_name = exp_name.pop_front();
        check($sformatf("%s_data", cur_name), out_data, cur_data);
        check($sformatf("%s_ovf", cur_name), {31'b0, overflow}, {31'b0, cur_ovf});
      end
    end
  end

  task automatic send(input logic [15:0] p, input logic [2:0] sh, input logic f, input logic l,
                      input bit push, input string name, input logic [31:0] d, input logic o);
    int budget;
    budget     = 0;
    in_product = p;
    in_shift   = sh;
    in_first   = f;
    in_last    = l;
    in_valid   = 1'b1;
    @(negedge clk);
    while (!in_ready && budget < 50) begin
      budget++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_accept actual=timeout required=accepted", name);
    end
    @(posedge clk);
    #1;
    if (l && push) begin
      exp_data.push_back(d);
      exp_ovf.push_back(o);
      exp_name.push_back(name);
    end
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 0;
    while (exp_data.size() != 0 && budget < 100) begin
      budget++;
      @(posedge clk);
    end
    #1;
    check($sformatf("%s_pending", name), 32'(exp_data.size()), 32'd0);
  endtask

  localparam logic [31:0] OVF_EXP =
`ifdef SIGNED_SPATIAL_ACC_SAT_EN
    32'h7FFF_FFFF;
`else
    32'h9FFE_C000;
`endif

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    @(posedge clk); #1;

    // basic group, back-to-back
    send(16'(100), 3'd0, 1'b1, 1'b0, 1'b0, "g80", 32'd0, 1'b0);
    send(16'(-50), 3'd0, 1'b0, 1'b0, 1'b0, "g80", 32'd0, 1'b0);
    send(16'(30),  3'd0, 1'b0, 1'b1, 1'b1, "g80", 32'd80, 1'b0);
    send(16'(3),   3'd2, 1'b1, 1'b0, 1'b0, "g47", 32'd0, 1'b0);
    send(16'(-1),  3'd0, 1'b0, 1'b1, 1'b1, "g47", 32'd47, 1'b0);
    drain("basic");

    // backpressure: second group stalls behind an unconsumed result
    out_ready = 1'b0;
    send(16'(100), 3'd0, 1'b1, 1'b0, 1'b0, "bp80", 32'd0, 1'b0);
    send(16'(-50), 3'd0, 1'b0, 1'b0, 1'b0, "bp80", 32'd0, 1'b0);
    send(16'(30),  3'd0, 1'b0, 1'b1, 1'b1, "bp80", 32'd80, 1'b0);
    send(16'(3),   3'd2, 1'b1, 1'b0, 1'b0, "bp47", 32'd0, 1'b0);
    send(16'(-1),  3'd0, 1'b0, 1'b1, 1'b1, "bp47", 32'd47, 1'b0);
    @(negedge clk);
    check("stall_in_ready", {31'b0, in_ready}, 32'd0);
    check("stall_out_valid", {31'b0, out_valid}, 32'd1);
    check("stall_out_data", out_data, 32'd80);
    repeat (2) @(negedge clk);
    check("stall_hold_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    drain("backpressure");

    // single-product group, shift clamp edge, restart and first-less groups
    send(16'h8000, 3'd0, 1'b1, 1'b1, 1'b1, "min_single", 32'hFFFF_8000, 1'b0);
    send(16'(1),   3'd7, 1'b1, 1'b1, 1'b1, "shift7", 32'd16384, 1'b0);
    send(16'(10),  3'd0, 1'b1, 1'b0, 1'b0, "restart", 32'd0, 1'b0);
    send(16'(20),  3'd0, 1'b0, 1'b0, 1'b0, "restart", 32'd0, 1'b0);
    send(16'(5),   3'd0, 1'b1, 1'b1, 1'b1, "restart", 32'd5, 1'b0);
    send(16'(7),   3'd0, 1'b0, 1'b0, 1'b0, "nofirst", 32'd0, 1'b0);
    send(16'(8),   3'd0, 1'b0, 1'b1, 1'b1, "nofirst", 32'd15, 1'b0);
    drain("misc");

    // five times 32767<<14 crosses +2^31
    send(16'h7FFF, 3'd7, 1'b1, 1'b0, 1'b0, "ovf", 32'd0, 1'b0);
    repeat (3) send(16'h7FFF, 3'd7, 1'b0, 1'b0, 1'b0, "ovf", 32'd0, 1'b0);
    send(16'h7FFF, 3'd7, 1'b0, 1'b1, 1'b1, "ovf", OVF_EXP, 1'b1);
    send(16'(4),   3'd0, 1'b1, 1'b1, 1'b1, "ovf_clear", 32'd4, 1'b0);
    drain("overflow");

    // reset mid-group with a result still held
    out_ready = 1'b0;
    send(16'(9), 3'd0, 1'b1, 1'b1, 1'b0, "lost", 32'd0, 1'b0);
    send(16'(1), 3'd0, 1'b1, 1'b0, 1'b0, "lost", 32'd0, 1'b0);
    send(16'(2), 3'd0, 1'b0, 1'b0, 1'b0, "lost", 32'd0, 1'b0);
    @(negedge clk);
    check("pre_rst_out_valid", {31'b0, out_valid}, 32'd1);
    check("pre_rst_out_data", out_data, 32'd9);
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_out_data", out_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    send(16'(5), 3'd0, 1'b1, 1'b0, 1'b0, "post_rst", 32'd0, 1'b0);
    send(16'(5), 3'd0, 1'b0, 1'b1, 1'b1, "post_rst", 32'd10, 1'b0);
    drain("reset");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
